// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage with branch squash, stall and halt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int                 PC_W       = 10,
    parameter int                 INSTR_W    = 9,
    parameter logic [INSTR_W-1:0] HALT_INSTR = {INSTR_W{1'b1}}
) (
    input  logic               CLK,
    input  logic               Reset_n,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_abs,
    input  logic               branch_rel,
    input  logic [PC_W-1:0]    target,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [PC_W-1:0]    PC,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic               Halt,
    output logic [31:0]        cycle_ct
);

    localparam logic [31:0] C_CYCLE_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [PC_W-1:0]    r_addr;
    logic [PC_W-1:0]    w_addr_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_halt;
    logic               w_halt_nxt;
    logic [31:0]        r_cycle;
    logic [31:0]        w_cycle_nxt;
    logic [PC_W-1:0]    w_rel_target;

    // Relative branches are taken from the address of the instruction being decoded.
    assign w_rel_target = r_addr + target;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_addr  <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_halt  <= 1'b0;
            r_cycle <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_addr_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
            r_halt  <= w_halt_nxt;
            r_cycle <= w_cycle_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = r_addr;
        w_instr_nxt = r_instr;
        w_valid_nxt = r_valid;
        w_halt_nxt  = r_halt;
        w_cycle_nxt = r_cycle;

        if (start) begin
            w_state_nxt = S_IDLE;
            w_pc_nxt    = '0;
            w_addr_nxt  = '0;
            w_instr_nxt = '0;
            w_valid_nxt = 1'b0;
            w_halt_nxt  = 1'b0;
            w_cycle_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = '0;
                    w_valid_nxt = 1'b0;
                end
                S_RUN: begin
                    if (!r_halt && (r_cycle != C_CYCLE_MAX)) begin
                        w_cycle_nxt = r_cycle + 32'd1;
                    end
                    // A stall freezes the whole fetch pipe and drops any branch request.
                    if (!stall) begin
                        if (r_valid && branch_abs) begin
                            w_pc_nxt    = target;
                            w_instr_nxt = instr_in;
                            w_addr_nxt  = r_pc;
                            w_valid_nxt = 1'b0;
                        end else if (r_valid && branch_rel) begin
                            w_pc_nxt    = w_rel_target;
                            w_instr_nxt = instr_in;
                            w_addr_nxt  = r_pc;
                            w_valid_nxt = 1'b0;
                        end else if (instr_in == HALT_INSTR) begin
                            w_instr_nxt = HALT_INSTR;
                            w_addr_nxt  = r_pc;
                            w_valid_nxt = 1'b1;
                            w_halt_nxt  = 1'b1;
                            w_state_nxt = S_HALTED;
                        end else begin
                            w_instr_nxt = instr_in;
                            w_addr_nxt  = r_pc;
                            w_valid_nxt = 1'b1;
                            w_pc_nxt    = r_pc + PC_W'(1);
                        end
                    end
                end
                S_HALTED: begin
                    w_valid_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign PC          = r_pc;
    assign instr_out   = r_instr;
    assign instr_valid = r_valid;
    assign Halt        = r_halt;
    assign cycle_ct    = r_cycle;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam logic [8:0] HALT = 9'h1FF;

    logic        CLK;
    logic        Reset_n;
    logic        start;
    logic        stall;
    logic        branch_abs;
    logic        branch_rel;
    logic [9:0]  target;
    logic [8:0]  instr_in;
    logic [9:0]  PC;
    logic [8:0]  instr_out;
    logic        instr_valid;
    logic        Halt;
    logic [31:0] cycle_ct;

    logic [8:0]  rom [0:1023];

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .CLK         (CLK),
        .Reset_n     (Reset_n),
        .start       (start),
        .stall       (stall),
        .branch_abs  (branch_abs),
        .branch_rel  (branch_rel),
        .target      (target),
        .instr_in    (instr_in),
        .PC          (PC),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .Halt        (Halt),
        .cycle_ct    (cycle_ct)
    );

    assign instr_in = rom[PC];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_rom();
        for (int i = 0; i < 1024; i++) rom[i] = {1'b0, i[7:0]};
    endtask

    // Behavioural model: fetched word, its address, validity, done flag, run-cycle count.
    logic [9:0]  m_pc     = '0;
    logic [9:0]  m_addr   = '0;
    logic [8:0]  m_out    = '0;
    logic        m_valid  = 1'b0;
    logic        m_active = 1'b0;
    logic        m_done   = 1'b0;
    logic [31:0] m_ct     = '0;

    always @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n || start) begin
            m_pc <= '0; m_addr <= '0; m_out <= '0; m_valid <= 1'b0;
            m_active <= 1'b0; m_done <= 1'b0; m_ct <= '0;
        end else if (!m_active) begin
            m_active <= 1'b1;
        end else if (!m_done) begin
            if (m_ct != 32'hFFFF_FFFF) m_ct <= m_ct + 32'd1;
            if (!stall) begin
                if (m_valid && branch_abs) begin
                    m_pc <= target; m_valid <= 1'b0;
                end else if (m_valid && branch_rel) begin
                    m_pc <= m_addr + target; m_valid <= 1'b0;
                end else if (rom[m_pc] == HALT) begin
                    m_out <= HALT; m_valid <= 1'b1; m_done <= 1'b1;
                end else begin
                    m_out <= rom[m_pc]; m_addr <= m_pc; m_valid <= 1'b1; m_pc <= m_pc + 10'd1;
                end
            end
        end else begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge CLK) begin
        chk("pc", {22'd0, PC}, {22'd0, m_pc});
        chk("valid", {31'd0, instr_valid}, {31'd0, m_valid});
        chk("halt", {31'd0, Halt}, {31'd0, m_done});
        chk("cycle_ct", cycle_ct, m_ct);
        if (m_valid || m_done || !m_active)
            chk("instr_out", {23'd0, instr_out}, {23'd0, m_out});
    end

    initial begin
        Reset_n = 1'b1; start = 1'b1; stall = 1'b0;
        branch_abs = 1'b0; branch_rel = 1'b0; target = '0;
        load_rom();
        #1 Reset_n = 1'b0;
        #2;
        chk("rst_pc", {22'd0, PC}, 32'd0);
        chk("rst_out", {23'd0, instr_out}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_halt", {31'd0, Halt}, 32'd0);
        chk("rst_ct", cycle_ct, 32'd0);
        #10 Reset_n = 1'b1;
        tick(); tick();

        // Sequential fetch into halt
        rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003; rom[3] = 9'h004; rom[4] = HALT;
        start = 1'b0;
        tick();
        chk("seq_idle_valid", {31'd0, instr_valid}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("seq_out", {23'd0, instr_out}, k);
            chk("seq_pc", {22'd0, PC}, k);
        end
        tick();
        chk("halt_out", {23'd0, instr_out}, 32'h1FF);
        chk("halt_valid", {31'd0, instr_valid}, 32'd1);
        chk("halt_flag", {31'd0, Halt}, 32'd1);
        chk("halt_pc", {22'd0, PC}, 32'd4);
        chk("halt_ct", cycle_ct, 32'd5);
        stall = 1'b1; branch_abs = 1'b1; target = 10'd20;
        tick();
        chk("halted_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("halted_pc", {22'd0, PC}, 32'd4);
        chk("halted_ct", cycle_ct, 32'd5);
        stall = 1'b0; branch_abs = 1'b0;

        // Absolute branch squashing a halt word at PC=3
        start = 1'b1;
        tick();
        chk("restart_halt", {31'd0, Halt}, 32'd0);
        load_rom(); rom[3] = HALT; rom[20] = 9'h155;
        start = 1'b0;
        repeat (4) tick();
        chk("abs_pre_out", {23'd0, instr_out}, 32'd2);
        chk("abs_pre_pc", {22'd0, PC}, 32'd3);
        branch_abs = 1'b1; target = 10'd20;
        tick();
        branch_abs = 1'b0;
        chk("abs_valid", {31'd0, instr_valid}, 32'd0);
        chk("abs_pc", {22'd0, PC}, 32'd20);
        chk("abs_nohalt", {31'd0, Halt}, 32'd0);
        tick();
        chk("abs_out", {23'd0, instr_out}, 32'h155);
        chk("abs_pc2", {22'd0, PC}, 32'd21);

        // Relative branch backwards across zero
        start = 1'b1;
        tick();
        load_rom();
        start = 1'b0;
        repeat (3) tick();
        branch_rel = 1'b1; target = 10'h3FE;
        tick();
        branch_rel = 1'b0;
        chk("rel_pc", {22'd0, PC}, 32'h3FF);
        chk("rel_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("wrap_pc", {22'd0, PC}, 32'd0);
        chk("wrap_out", {23'd0, instr_out}, 32'h0FF);

        // Stall with a simultaneous branch
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("stall_pre_pc", {22'd0, PC}, 32'd5);
        stall = 1'b1; branch_abs = 1'b1; target = 10'd100;
        repeat (3) tick();
        chk("stall_pc", {22'd0, PC}, 32'd5);
        chk("stall_out", {23'd0, instr_out}, 32'd4);
        chk("stall_ct", cycle_ct, 32'd8);
        stall = 1'b0; branch_abs = 1'b0;
        tick();
        chk("post_stall_pc", {22'd0, PC}, 32'd6);
        chk("post_stall_out", {23'd0, instr_out}, 32'd5);

        // Asynchronous reset mid-run, then restart
        #2 Reset_n = 1'b0;
        #1;
        chk("async_pc", {22'd0, PC}, 32'd0);
        chk("async_ct", cycle_ct, 32'd0);
        chk("async_out", {23'd0, instr_out}, 32'd0);
        start = 1'b1;
        rom[0] = 9'h0AA;
        #2 Reset_n = 1'b1;
        tick(); tick();
        start = 1'b0;
        tick();
        chk("rs_ct0", cycle_ct, 32'd0);
        tick();
        chk("rs_out", {23'd0, instr_out}, 32'h0AA);
        chk("rs_ct1", cycle_ct, 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
